// File: rtl/enemy_pkg.sv
// ============================================================================
// Module   : enemy_pkg
// Brief    : Shared types, constants and the per-axis motion helper for the
//            enemy sprite controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_pkg;

    typedef enum logic [1:0] {
        DESPAWN = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2
    } enemy_state_t;

    typedef logic signed [10:0] coord_t;

    typedef struct packed {
        logic [9:0]        pos;
        logic signed [4:0] vel;
    } axis_upd_t;

    localparam logic [11:0] TRANSP_DEFAULT = 12'h111;
    localparam logic [9:0]  OFFSCREEN      = 10'h3FF;

    // One axis of motion; chase never touches the stored velocity.
    function automatic axis_upd_t axis_move(
        input logic              chase,
        input logic [9:0]        pos,
        input logic signed [4:0] vel,
        input logic [3:0]        step,
        input logic [9:0]        target,
        input int                size,
        input int                lim
    );
        axis_upd_t  r;
        coord_t     p;
        coord_t     t;
        coord_t     s;
        coord_t     d;
        coord_t     mag;
        coord_t     nx;
        logic [11:0] ext;
        p = coord_t'({1'b0, pos});
        t = coord_t'({1'b0, target});
        s = coord_t'({7'd0, step});
        r.vel = vel;
        if (chase) begin
            d   = t - p;
            mag = (d < 0) ? -d : d;
            if (mag <= s) begin
                nx = t;
            end else begin
                nx = (d < 0) ? (p - s) : (p + s);
            end
        end else begin
            nx = p + coord_t'(vel);
        end
        ext = {nx[10], nx};
        if (nx < 0) begin
            r.pos = 10'd0;
            if (!chase) r.vel = $signed({1'b0, step});
        end else if ((ext + 12'(size)) > 12'(lim + 1)) begin
            r.pos = 10'(lim + 1 - size);
            if (!chase) r.vel = -$signed({1'b0, step});
        end else begin
            r.pos = nx[9:0];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_tick_sync.sv
// ============================================================================
// Module   : frame_tick_sync
// Brief    : Two-flop synchroniser plus rising-edge detect, registered tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tick_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic frame_clk,
    output logic tick
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;
    logic       tick_q;
    logic       tick_d;

    always_comb begin
        sync_d = {sync_q[1:0], frame_clk};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= 3'b000;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/enemy_sprite_ctrl.sv
// ============================================================================
// Module   : enemy_sprite_ctrl
// Brief    : One enemy sprite: bounce/chase motion, pixel hit, kill + grace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_sprite_ctrl
    import enemy_pkg::*;
#(
    parameter int          SPR_W   = 40,
    parameter int          SPR_H   = 40,
    parameter int          X_MAX   = 639,
    parameter int          Y_MAX   = 479,
    parameter int          GRACE_W = 26,
    parameter logic [11:0] TRANSP  = TRANSP_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        frame_clk,
    input  logic        spawn,
    input  logic        pause,
    input  logic        invincible,
    input  logic        mode,
    input  logic [9:0]  x_start,
    input  logic [9:0]  y_start,
    input  logic [3:0]  x_step,
    input  logic [3:0]  y_step,
    input  logic [9:0]  jerry_x,
    input  logic [9:0]  jerry_y,
    input  logic        jerry_active,
    input  logic [11:0] colors_a,
    input  logic [11:0] colors_b,
    input  logic        anim_sel,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [11:0] color,
    output logic [6:0]  idx_x,
    output logic [6:0]  idx_y,
    output logic        active,
    output logic        killed_jerry,
    output logic        in_grace,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y
);

    enemy_state_t        state_q, state_d;
    logic [9:0]          pos_x_q, pos_x_d;
    logic [9:0]          pos_y_q, pos_y_d;
    logic signed [4:0]   vx_q, vx_d;
    logic signed [4:0]   vy_q, vy_d;
    logic                killed_q, killed_d;
    logic [GRACE_W-1:0]  grace_q, grace_d;
    logic                in_grace_q, in_grace_d;

    logic                w_tick;
    logic                w_kill;
    logic                w_in_x;
    logic                w_in_y;
    logic [10:0]         w_dx, w_dy, w_px, w_py;
    axis_upd_t           w_upd_x, w_upd_y;

    frame_tick_sync u_tick (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    // Bounds are widened so a sprite near 3FF never wraps back onto screen.
    always_comb begin
        w_dx   = {1'b0, draw_x};
        w_dy   = {1'b0, draw_y};
        w_px   = {1'b0, pos_x_q};
        w_py   = {1'b0, pos_y_q};
        w_in_x = (w_dx >= w_px) && (w_dx < (w_px + 11'(SPR_W)));
        w_in_y = (w_dy >= w_py) && (w_dy < (w_py + 11'(SPR_H)));
        color  = anim_sel ? colors_a : colors_b;
        active = (state_q == RUN) && w_in_x && w_in_y && (color != TRANSP);
        idx_x  = 7'(draw_x - pos_x_q);
        idx_y  = 7'(draw_y - pos_y_q);
    end

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        grace_d  = grace_q;
        w_upd_x  = axis_move(mode, pos_x_q, vx_q, x_step, jerry_x, SPR_W, X_MAX);
        w_upd_y  = axis_move(mode, pos_y_q, vy_q, y_step, jerry_y, SPR_H, Y_MAX);
        w_kill   = active & jerry_active & ~invincible & (grace_q == '0)
                 & ~killed_q & spawn;
        killed_d = w_kill;

        if (w_kill) begin
            grace_d = GRACE_W'(1);
        end else if (grace_q != '0) begin
            grace_d = grace_q + GRACE_W'(1);
        end

        case (state_q)
            DESPAWN: begin
                if (spawn) state_d = LOAD;
            end
            LOAD: begin
                pos_x_d = x_start;
                pos_y_d = y_start;
                vx_d    = $signed({1'b0, x_step});
                vy_d    = $signed({1'b0, y_step});
                state_d = RUN;
            end
            RUN: begin
                if (w_tick && !pause) begin
                    pos_x_d = w_upd_x.pos;
                    pos_y_d = w_upd_y.pos;
                    vx_d    = w_upd_x.vel;
                    vy_d    = w_upd_y.vel;
                end
            end
            default: state_d = DESPAWN;
        endcase

        // Losing spawn overrides motion, loading and any pending kill.
        if (!spawn) begin
            state_d  = DESPAWN;
            pos_x_d  = OFFSCREEN;
            pos_y_d  = OFFSCREEN;
            grace_d  = '0;
            killed_d = 1'b0;
        end

        in_grace_d = (grace_d != '0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= DESPAWN;
            pos_x_q    <= OFFSCREEN;
            pos_y_q    <= OFFSCREEN;
            vx_q       <= '0;
            vy_q       <= '0;
            killed_q   <= 1'b0;
            grace_q    <= '0;
            in_grace_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            killed_q   <= killed_d;
            grace_q    <= grace_d;
            in_grace_q <= in_grace_d;
        end
    end

    assign killed_jerry = killed_q;
    assign in_grace     = in_grace_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_sprite_ctrl.sv
// ============================================================================
// Module   : tb_enemy_sprite_ctrl
// Brief    : Directed self-checking bench for enemy_sprite_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_sprite_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        frame_clk, spawn, pause, invincible, mode;
    logic [9:0]  x_start, y_start, jerry_x, jerry_y, draw_x, draw_y;
    logic [3:0]  x_step, y_step;
    logic        jerry_active, anim_sel;
    logic [11:0] colors_a, colors_b;
    logic [11:0] color;
    logic [6:0]  idx_x, idx_y;
    logic        active, killed_jerry, in_grace;
    logic [9:0]  pos_x, pos_y;

    int checks   = 0;
    int failures = 0;
    int pulses, grace_cnt, long_pulse, first_idx, second_idx;

    enemy_sprite_ctrl #(.GRACE_W(4)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .frame_clk    (frame_clk),
        .spawn        (spawn),
        .pause        (pause),
        .invincible   (invincible),
        .mode         (mode),
        .x_start      (x_start),
        .y_start      (y_start),
        .x_step       (x_step),
        .y_step       (y_step),
        .jerry_x      (jerry_x),
        .jerry_y      (jerry_y),
        .jerry_active (jerry_active),
        .colors_a     (colors_a),
        .colors_b     (colors_b),
        .anim_sel     (anim_sel),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .color        (color),
        .idx_x        (idx_x),
        .idx_y        (idx_y),
        .active       (active),
        .killed_jerry (killed_jerry),
        .in_grace     (in_grace),
        .pos_x        (pos_x),
        .pos_y        (pos_y)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        cyc(5);
        frame_clk = 1'b0;
        cyc(3);
    endtask

    initial begin
        RESET_N = 1'b0; frame_clk = 0; spawn = 0; pause = 0; invincible = 0; mode = 0;
        x_start = 0; y_start = 0; x_step = 0; y_step = 0; jerry_x = 0; jerry_y = 0;
        jerry_active = 0; colors_a = 0; colors_b = 0; anim_sel = 0; draw_x = 0; draw_y = 0;
        cyc(2);
        check_val("rst_pos_x", pos_x, 10'h3FF);
        check_val("rst_pos_y", pos_y, 10'h3FF);
        check_val("rst_killed", killed_jerry, 0);
        check_val("rst_grace", in_grace, 0);
        check_val("rst_active", active, 0);
        RESET_N = 1'b1;
        cyc(1);

        // Basic bounce move
        x_start = 100; y_start = 100; x_step = 2; y_step = 3; mode = 0; spawn = 1;
        cyc(3);
        check_val("load_x", pos_x, 100);
        frame_tick();
        check_val("t1_x", pos_x, 102);
        check_val("t1_y", pos_y, 103);

        // Right and left walls
        spawn = 0; cyc(1);
        check_val("despawn_x", pos_x, 10'h3FF);
        x_start = 598; y_start = 100; x_step = 4; y_step = 0; spawn = 1;
        cyc(3);
        frame_tick();
        check_val("bounce_r_x", pos_x, 600);
        frame_tick();
        check_val("bounce_r_vx", pos_x, 596);
        mode = 1; jerry_x = 2; jerry_y = 100; x_step = 15; y_step = 15;
        repeat (42) frame_tick();
        check_val("chase_to_2_x", pos_x, 2);
        check_val("chase_to_2_y", pos_y, 100);
        mode = 0; x_step = 4; y_step = 0;
        frame_tick();
        check_val("bounce_l_x", pos_x, 0);
        frame_tick();
        check_val("bounce_l_vx", pos_x, 4);

        // Chase step
        spawn = 0; cyc(1);
        x_start = 200; y_start = 200; x_step = 5; y_step = 5; mode = 1;
        jerry_x = 203; jerry_y = 150; spawn = 1;
        cyc(3);
        frame_tick();
        check_val("chase_x", pos_x, 203);
        check_val("chase_y", pos_y, 195);

        // Pixel hit, index, palette select
        pause = 1; draw_x = 210; draw_y = 200; colors_a = 12'hABC; colors_b = 12'h111; anim_sel = 1;
        cyc(1);
        check_val("active_hit", active, 1);
        check_val("idx_x", idx_x, 7);
        check_val("idx_y", idx_y, 5);
        check_val("color_a", color, 12'hABC);
        anim_sel = 0;
        cyc(1);
        check_val("color_b", color, 12'h111);
        check_val("active_transp", active, 0);

        // Transparent and invincible overlaps must not kill
        jerry_active = 1; pulses = 0;
        repeat (5) begin cyc(1); pulses += int'(killed_jerry); end
        anim_sel = 1; invincible = 1;
        repeat (5) begin cyc(1); pulses += int'(killed_jerry); end
        check_val("no_kill_masked", pulses, 0);

        // Held overlap: one pulse, 15-cycle grace
        invincible = 0; pulses = 0; grace_cnt = 0; long_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) jerry_active = 0;
            cyc(1);
            if (killed_jerry && pulses > 0 && i > 0) long_pulse++;
            pulses    += int'(killed_jerry);
            grace_cnt += int'(in_grace);
        end
        check_val("single_pulse", pulses, 1);
        check_val("pulse_width", long_pulse, 0);
        check_val("grace_len", grace_cnt, 15);

        // Second pulse only after wrap
        jerry_active = 1; pulses = 0; first_idx = -1; second_idx = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (killed_jerry) begin
                if (first_idx < 0) first_idx = i;
                else second_idx = i;
                pulses++;
            end
        end
        jerry_active = 0;
        check_val("rekill_count", pulses, 2);
        check_val("rekill_gap", second_idx - first_idx, 16);

        // Pause freezes position
        jerry_x = 300; jerry_y = 150;
        repeat (5) frame_tick();
        check_val("pause_x", pos_x, 203);
        check_val("pause_y", pos_y, 195);
        pause = 0;
        frame_tick();
        check_val("unpause_x", pos_x, 208);
        check_val("unpause_y", pos_y, 190);

        // Despawn mid-grace
        jerry_active = 1; cyc(1); jerry_active = 0;
        check_val("kill_t6", killed_jerry, 1);
        cyc(2);
        check_val("grace_t6", in_grace, 1);
        spawn = 0; cyc(1);
        check_val("desp_x", pos_x, 10'h3FF);
        check_val("desp_y", pos_y, 10'h3FF);
        check_val("desp_grace", in_grace, 0);

        // Asynchronous reset mid-flight
        x_start = 100; y_start = 100; x_step = 2; y_step = 3; mode = 0; spawn = 1;
        cyc(3);
        frame_tick();
        check_val("pre_rst_x", pos_x, 102);
        draw_x = 110; draw_y = 110;
        jerry_active = 1; cyc(1); jerry_active = 0; cyc(1);
        check_val("pre_rst_grace", in_grace, 1);
        #2 RESET_N = 1'b0;
        #1;
        check_val("arst_x", pos_x, 10'h3FF);
        check_val("arst_y", pos_y, 10'h3FF);
        check_val("arst_grace", in_grace, 0);
        check_val("arst_killed", killed_jerry, 0);
        check_val("arst_active", active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
